tern_coef_bus_arbiter: RTL and testbench



---
 rtl/tern_bus_pkg.sv | 27 ++
 rtl/mux4.sv | 11 +
 rtl/rr_pick4.sv | 28 ++
 rtl/tern_coef_bus_arbiter.sv | 113 +++++++++++
 tb/tb_tern_coef_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tern_bus_pkg.sv
// Shared types and constants for the ternary coefficient bus arbiter.
// Contents: the FSM state enum, the 2-bit ternary coefficient type and its
// encodings, the requester count, and a one-hot helper.
package tern_bus_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned NTRU_N = 701;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Ternary coefficient: 00 = 0, 01 = +1, 11 = -1 (10 unused)
    typedef logic [1:0] tern_t;
    localparam tern_t TERN_ZERO = 2'b00;
    localparam tern_t TERN_POS  = 2'b01;
    localparam tern_t TERN_NEG  = 2'b11;

    // Binary index to one-hot requester vector
    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4.sv
// Single-bit 4:1 multiplexer.
// Ports: d (four data inputs), s (select), y (selected bit).
module mux4 (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority encoder for four requesters.
// Ports: req (request vector), ptr (index of the last winner),
//        winner (index of the next winner), any (at least one request).
// Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] cand;

    // Walk from lowest to highest priority so the nearest requester wins last
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        cand   = ptr;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tern_coef_bus_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one ternary coefficient
// stream between four producers.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   req         per-requester request, held for the whole burst
//   coef_in     packed coefficients, bits [2i+1:2i] from requester i
//   out_ready   downstream accepts a coefficient this cycle
//   gnt, sel    one-hot grant and its binary index (mux select)
//   adv         one-hot: requester i moves to its next coefficient
//   coef_out    muxed coefficient of the granted requester
//   coef_valid  coef_out is valid; last marks the final beat; busy = in burst
module tern_coef_bus_arbiter
    import tern_bus_pkg::*;
#(
    parameter int unsigned BURST_LEN = NTRU_N,
    parameter int unsigned CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] coef_in,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [3:0] adv,
    output logic [1:0] coef_out,
    output logic       coef_valid,
    output logic       last,
    output logic       busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic             beat;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // Coefficient path: one bit-slice mux per coefficient bit
    mux4 u_mux_lo (
        .d ({coef_in[6], coef_in[4], coef_in[2], coef_in[0]}),
        .s (sel),
        .y (coef_out[0])
    );

    mux4 u_mux_hi (
        .d ({coef_in[7], coef_in[5], coef_in[3], coef_in[1]}),
        .s (sel),
        .y (coef_out[1])
    );

    assign beat = coef_valid & out_ready;
    assign adv  = gnt & {N_REQ{out_ready}};

    // Burst FSM; last is kept registered as (cnt == BURST_LEN-1) and only
    // advanced on accepted beats so it holds through stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            coef_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            ptr        <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt        <= onehot4(pick_idx);
                        sel        <= pick_idx;
                        cnt        <= '0;
                        coef_valid <= 1'b1;
                        busy       <= 1'b1;
                        last       <= (BURST_LEN == 1);
                        state      <= XFER;
                    end
                end
                XFER: begin
                    // Final beat does not increment, so cnt never passes BURST_LEN-1
                    if (beat && !last) begin
                        cnt  <= cnt + CNT_W'(1);
                        last <= ((cnt + CNT_W'(1)) == CNT_W'(BURST_LEN - 1));
                    end
                    // Completion or abort by the granted requester
                    if ((beat && last) || !req[sel]) begin
                        gnt        <= '0;
                        coef_valid <= 1'b0;
                        busy       <= 1'b0;
                        last       <= 1'b0;
                        ptr        <= sel;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tern_coef_bus_arbiter.sv
module tb_tern_coef_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [7:0] coef_in;
    logic       out_ready = 1'b1;
    logic [3:0] gnt, adv;
    logic [1:0] sel, coef_out;
    logic       coef_valid, last, busy;

    logic [3:0] req2 = 4'b0000;
    logic [7:0] coef_in2;
    logic       out_ready2 = 1'b0;
    logic [3:0] gnt2, adv2;
    logic [1:0] sel2, coef_out2;
    logic       coef_valid2, last2, busy2;

    tern_coef_bus_arbiter #(.BURST_LEN(4), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .coef_in(coef_in),
        .out_ready(out_ready), .gnt(gnt), .sel(sel), .adv(adv),
        .coef_out(coef_out), .coef_valid(coef_valid), .last(last), .busy(busy)
    );

    tern_coef_bus_arbiter dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .coef_in(coef_in2),
        .out_ready(out_ready2), .gnt(gnt2), .sel(sel2), .adv(adv2),
        .coef_out(coef_out2), .coef_valid(coef_valid2), .last(last2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] tern3(input int k);
        case (k % 3)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // Producers: each requester steps through its table on adv
    logic [1:0] coef_tab [4][4];
    logic [1:0] pidx [4] = '{default: 2'd0};
    logic [9:0] p2 = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (adv[i]) pidx[i] <= pidx[i] + 2'd1;
        if (adv2[2]) p2 <= p2 + 10'd1;
    end

    always_comb begin
        coef_in = '0;
        for (int i = 0; i < 4; i++)
            coef_in[2*i +: 2] = coef_tab[i][pidx[i]];
    end

    always_comb begin
        coef_in2 = {2'b00, tern3(int'(p2)), 4'b0000};
    end

    // Scoreboard for the BURST_LEN=4 instance
    typedef struct {
        logic [1:0] sel;
        logic [1:0] coef;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    bit    mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("adv", 32'(adv), 32'(gnt & {4{out_ready}}));
            check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            if (coef_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sel", 32'(sel), 32'(exp_q[0].sel));
                    check("gnt_vs_sel", 32'(gnt), 32'(4'b0001 << exp_q[0].sel));
                    check("coef_out", 32'(coef_out), 32'(exp_q[0].coef));
                    check("last", 32'(last), 32'(exp_q[0].last));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("last_idle", 32'(last), 32'd0);
            end
        end
    end

    // Beat counter for the BURST_LEN=701 instance
    bit mon2_en = 1'b0;
    int b2 = 0;
    int last2_cnt = 0;
    int last2_at = 0;

    always @(negedge clk) begin
        if (mon2_en && coef_valid2 && out_ready2) begin
            check("coef_out2", 32'(coef_out2), 32'(tern3(b2)));
            b2++;
            if (last2) begin
                last2_cnt++;
                last2_at = b2;
            end
        end
    end

    task automatic start_burst(input logic [3:0] r, input logic [3:0] eg, input int ew,
                               input int nbeats, input bit full);
        int w = 0;
        int ei = 0;
        req = r;
        while (!coef_valid && w < 8) begin
            tick();
            w++;
        end
        check("grant_wait", 32'(w), 32'(ew));
        check("gnt", 32'(gnt), 32'(eg));
        check("busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++)
            if (eg[i]) ei = i;
        for (int k = 0; k < nbeats; k++) begin
            beat_t b;
            b.sel  = 2'(ei);
            b.coef = coef_tab[ei][2'(int'(pidx[ei]) + k)];
            b.last = full && (k == nbeats - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic finish_burst(input logic [7:0] pat, input int plen, input int ecyc);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            out_ready = pat[k % plen];
            tick();
            k++;
        end
        check("burst_done", 32'(exp_q.size()), 32'd0);
        check("burst_cycles", 32'(k), 32'(ecyc));
        exp_q.delete();
        out_ready = 1'b1;
        check("rel_valid", 32'(coef_valid), 32'd0);
        check("rel_gnt", 32'(gnt), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        int         w;
        logic [7:0] pat;
        int         plen;
        int         cyc;
    } row_t;

    row_t rows [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        coef_tab[0] = '{2'b01, 2'b11, 2'b00, 2'b01};
        coef_tab[1] = '{2'b11, 2'b01, 2'b01, 2'b00};
        coef_tab[2] = '{2'b00, 2'b11, 2'b01, 2'b11};
        coef_tab[3] = '{2'b01, 2'b00, 2'b11, 2'b11};

        // {req, expected gnt, cycles to grant, out_ready pattern, pattern length, burst cycles}
        rows[0] = '{4'b0001, 4'b0001, 1, 8'hFF, 1, 4};
        rows[1] = '{4'b1111, 4'b0010, 2, 8'hFF, 1, 4};
        rows[2] = '{4'b1111, 4'b0100, 2, 8'hFF, 1, 4};
        rows[3] = '{4'b1111, 4'b1000, 2, 8'hFF, 1, 4};
        rows[4] = '{4'b1111, 4'b0001, 2, 8'hFF, 1, 4};
        rows[5] = '{4'b1010, 4'b0010, 2, 8'h59, 7, 7};
        rows[6] = '{4'b1010, 4'b1000, 2, 8'hFF, 1, 4};
        rows[7] = '{4'b0110, 4'b0010, 2, 8'hFF, 1, 4};
        rows[8] = '{4'b1001, 4'b1000, 2, 8'hFF, 1, 4};

        // Reset with a request pending: nothing may be granted
        rst_n = 1'b0;
        req = 4'b0001;
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_adv", 32'(adv), 32'd0);
        check("rst_valid", 32'(coef_valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt2", 32'(gnt2), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start_burst(rows[i].r, rows[i].g, rows[i].w, 4, 1'b1);
            finish_burst(rows[i].pat, rows[i].plen, rows[i].cyc);
        end

        // Abort: requester 2 drops req after two beats; a third beat in the drop cycle still counts
        start_burst(4'b0100, 4'b0100, 2, 3, 1'b0);
        tick();
        tick();
        req = 4'b0000;
        tick();
        check("abort_valid", 32'(coef_valid), 32'd0);
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_beats", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        // Aborter loses priority: 0 before 2
        start_burst(4'b0101, 4'b0001, 2, 4, 1'b1);
        finish_burst(8'hFF, 1, 4);

        // Reset in the second beat of a burst
        start_burst(4'b0010, 4'b0010, 2, 4, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_gnt", 32'(gnt), 32'd0);
        check("mrst_valid", 32'(coef_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_last", 32'(last), 32'd0);
        check("mrst_sel", 32'(sel), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        // ptr back at 3: requester 0 beats 3
        start_burst(4'b1001, 4'b0001, 1, 4, 1'b1);
        finish_burst(8'hFF, 1, 4);
        start_burst(4'b1000, 4'b1000, 2, 4, 1'b1);
        finish_burst(8'hFF, 1, 4);
        req = 4'b0000;
        tick();
        tick();
        check("quiet_valid", 32'(coef_valid), 32'd0);

        // Full-length burst on the default instance with random stalls
        begin
            int w2 = 0;
            int cyc = 0;
            mon2_en = 1'b1;
            req2 = 4'b0100;
            out_ready2 = 1'b1;
            while (!coef_valid2 && w2 < 5) begin
                tick();
                w2++;
            end
            check("g2_wait", 32'(w2), 32'd1);
            check("g2_gnt", 32'(gnt2), 32'b0100);
            while (cyc < 3000 && !(last2_cnt > 0 && !coef_valid2)) begin
                out_ready2 = ($urandom_range(0, 3) != 0);
                tick();
                cyc++;
                if (last2_cnt > 0) req2 = 4'b0000;
            end
            check("b2_timeout", 32'(cyc < 3000), 32'd1);
            check("b2_beats", 32'(b2), 32'd701);
            check("b2_last_count", 32'(last2_cnt), 32'd1);
            check("b2_last_at", 32'(last2_at), 32'd701);
            check("b2_busy", 32'(busy2), 32'd0);
            tick();
            tick();
            check("b2_quiet", 32'(coef_valid2), 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
